// File: rtl/add_accum.sv
// Frame accumulator: sums FRAME_LEN handshaked operands through an external
// combinational adder and presents the wrapped sum plus a sticky carry flag.
module add_accum #(
    parameter int BIT_NUM   = 8,
    parameter int FRAME_LEN = 4
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [BIT_NUM-1:0] IN_DATA,
    output logic [BIT_NUM-1:0] ADD_A,
    output logic [BIT_NUM-1:0] ADD_B,
    input  logic [BIT_NUM-1:0] ADD_O,
    input  logic               ADD_C,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [BIT_NUM-1:0] OUT_SUM,
    output logic               OUT_OVF
);

    typedef enum logic [1:0] {
        INIT,
        COLLECT,
        HOLD
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(FRAME_LEN - 1);

    state_t             state;
    state_t             state_next;
    logic [BIT_NUM-1:0] acc;
    logic [7:0]         cnt;
    logic               ovf;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               accept;
    logic               out_accept;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        out_accept = 1'b0;
        case (state)
            INIT: state_next = COLLECT;
            COLLECT: begin
                if (IN_VALID) begin
                    accept = 1'b1;
                    if (cnt == LAST_CNT) begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (OUT_READY) begin
                    out_accept = 1'b1;
                    state_next = COLLECT;
                end
            end
            default: state_next = INIT;
        endcase
    end

    // Handshake flags are flopped from the next state so they are glitch-free
    // and carry no combinational path from IN_VALID or OUT_READY.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= INIT;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_next;
            in_ready_q  <= (state_next == COLLECT);
            out_valid_q <= (state_next == HOLD);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N || out_accept) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (accept) begin
            acc <= ADD_O;
            cnt <= cnt + 8'd1;
            ovf <= ovf | ADD_C;
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign ADD_A     = acc;
    assign ADD_B     = IN_DATA;
    assign OUT_SUM   = acc;
    assign OUT_OVF   = ovf;

endmodule
